semi_procesador_param: RTL



---
 rtl/semi_procesador_param_if.sv | 27 ++
 rtl/semi_procesador_param.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/semi_procesador_param_if.sv
// Switch/LED bus of the parametrised semi-processor: operand entry, result display
// and history read port.
interface semi_procesador_param_if #(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    logic [W-1:0]             sw;
    logic [2:0]               op;
    logic                     load;
    logic [W-1:0]             leds;
    logic [2:0]               flags;
    logic                     busy;
    logic                     done;
    logic [$clog2(DEPTH)-1:0] hist_sel;
    logic [W-1:0]             hist_data;
    logic                     hist_valid;

    modport master (
        output sw, op, load, hist_sel,
        input  leds, flags, busy, done, hist_data, hist_valid
    );

    modport slave (
        input  sw, op, load, hist_sel,
        output leds, flags, busy, done, hist_data, hist_valid
    );
endinterface

// File: rtl/semi_procesador_param.sv
// Parametrised semi-processor: A, then B+opcode, one-cycle ALU execute, result/flags
// on LEDs and a circular result history. Define SEMI_PROC_MUL_EN to make opcode 111 a MUL.
module semi_procesador_param #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int SHW   = $clog2(W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    semi_procesador_param_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_A, S_B, S_EXEC, S_SHOW} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q, leds_q;
    logic [2:0]     opc_q, flags_q;
    logic           done_q;
    logic [AW-1:0]  wp_q;
    logic [AW:0]    cnt_q;
    logic [W-1:0]   hist_q [DEPTH];

    logic [W-1:0]   res;
    logic           carry, ovf;
    logic [W:0]     sum;
    logic [2*W-1:0] shl_x, shr_x;
    logic [SHW-1:0] amt;
`ifdef SEMI_PROC_MUL_EN
    logic [2*W-1:0] prod;
`endif

    // Shifts run through a double-width vector so the last bit shifted out lands
    // at a fixed position regardless of the amount.
    always_comb begin
        amt   = b_q[SHW-1:0];
        shl_x = {{W{1'b0}}, a_q} << amt;
        shr_x = {a_q, {W{1'b0}}} >> amt;
        sum   = '0;
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
`ifdef SEMI_PROC_MUL_EN
        prod  = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
`endif
        case (opc_q)
            3'b000: begin
                sum   = {1'b0, a_q} + {1'b0, b_q};
                res   = sum[W-1:0];
                carry = sum[W];
                ovf   = (a_q[W-1] == b_q[W-1]) && (res[W-1] != a_q[W-1]);
            end
            3'b001: begin
                sum   = {1'b0, a_q} - {1'b0, b_q};
                res   = sum[W-1:0];
                carry = sum[W];
                ovf   = (a_q[W-1] != b_q[W-1]) && (res[W-1] != a_q[W-1]);
            end
            3'b010: res = a_q & b_q;
            3'b011: res = a_q | b_q;
            3'b100: res = a_q ^ b_q;
            3'b101: begin
                res   = shl_x[W-1:0];
                carry = (amt != '0) && shl_x[W];
            end
            3'b110: begin
                res   = shr_x[2*W-1:W];
                carry = (amt != '0) && shr_x[W-1];
            end
            default: begin
`ifdef SEMI_PROC_MUL_EN
                res   = prod[W-1:0];
                carry = |prod[2*W-1:W];
`else
                res   = a_q;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_A;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_A:     if (bus.load) state_d = S_B;
            S_B:     if (bus.load) state_d = S_EXEC;
            S_EXEC:  state_d = S_SHOW;
            S_SHOW:  if (bus.load) state_d = S_B;
            default: state_d = S_A;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == S_EXEC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            opc_q   <= '0;
            leds_q  <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            wp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= (state_q == S_EXEC);
            case (state_q)
                S_A, S_SHOW: if (bus.load) begin
                    a_q    <= bus.sw;
                    leds_q <= bus.sw;
                end
                S_B: if (bus.load) begin
                    b_q    <= bus.sw;
                    opc_q  <= bus.op;
                    leds_q <= bus.sw;
                end
                S_EXEC: begin
                    leds_q  <= res;
                    flags_q <= {ovf, carry, (res == '0)};
                    wp_q    <= wp_q + AW'(1);
                    if (cnt_q != (AW+1)'(DEPTH)) cnt_q <= cnt_q + (AW+1)'(1);
                end
                default: ;
            endcase
        end
    end

    // History contents survive reset; only the count and pointer are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == S_EXEC) hist_q[wp_q] <= res;
    end

    logic [AW-1:0] rd_idx;
    assign rd_idx         = wp_q - AW'(1) - bus.hist_sel;
    assign bus.hist_data  = hist_q[rd_idx];
    assign bus.hist_valid = ({1'b0, bus.hist_sel} < cnt_q);
    assign bus.leds       = leds_q;
    assign bus.flags      = flags_q;
    assign bus.done       = done_q;
endmodule
